// File: rtl/memoria_bus.sv
// Word-addressed memory behind a req/ack bus with a fixed number of wait states.
// Optional write protection below ROM_TOP: define MEMORIA_BUS_PROTECT_EN.
module memoria_bus #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter int                DEPTH       = 65536,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] ROM_TOP     = 16'h0100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              le,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WS      = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                le_q, le_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                commit;

    logic [DATA_W-1:0]   mem [DEPTH];

    // With zero wait states the commit edge is also the sampling edge,
    // so the transaction fields come straight from the bus in IDLE.
    logic [ADDR_W-1:0]   tx_addr;
    logic                tx_le;
    logic [DATA_W-1:0]   tx_wdata;
    logic                tx_in, q_in;
    logic                tx_prot, q_prot;
    logic [IDX_W-1:0]    tx_idx;
    logic                wr_en;

    assign tx_addr  = (state_q == IDLE) ? addr  : addr_q;
    assign tx_le    = (state_q == IDLE) ? le    : le_q;
    assign tx_wdata = (state_q == IDLE) ? wdata : wdata_q;
    assign tx_idx   = tx_addr[IDX_W-1:0];
    assign tx_in    = {1'b0, tx_addr} < DEPTH_L;
    assign q_in     = {1'b0, addr_q} < DEPTH_L;

`ifdef MEMORIA_BUS_PROTECT_EN
    assign tx_prot  = !tx_le && (tx_addr < ROM_TOP);
    assign q_prot   = !le_q && (addr_q < ROM_TOP);
`else
    logic unused_rom;
    assign unused_rom = ^ROM_TOP;
    assign tx_prot    = 1'b0;
    assign q_prot     = 1'b0;
`endif

    assign wr_en = commit && !tx_le && tx_in && !tx_prot;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        le_d    = le_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    le_d    = le;
                    wdata_d = wdata;
                    cnt_d   = WS;
                    if (WS == 4'd0) begin
                        state_d = ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ACK;
                    commit  = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (commit && tx_le) begin
            rdata_d = tx_in ? mem[tx_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            le_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            le_q    <= le_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory is never cleared; reset only suppresses a coinciding commit.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[tx_idx] <= tx_wdata;
        end
    end

    assign rdata = rdata_q;
    assign ack   = (state_q == ACK);
    assign busy  = (state_q != IDLE);
    assign err   = (state_q == ACK) && (!q_in || q_prot);

endmodule
